vga_fb_arbiter: RTL and testbench
=================================

// Module: vga_fb_arbiter
// PURPOSE
// Owns the single-port tile framebuffer RAM of the scoreboard display and shares it between three users.
// - VGA tile fetch: fixed, highest priority. Driven by the vga timing counters (horizontal_x/vertical_y).
// - Scoreboard writer: req/ack handshake.
// - Built-in clear sequencer: fills the whole RAM with CLR_VAL.
// The fetched tile code goes to the downstream glyph renderer.
// PARAMETERS
// H_VIZ    640   visible pixels per line
// V_VIZ    480   visible lines per frame
// H_TOTAL  800   pixel clocks per line (horizontal_x range 0..H_TOTAL-1)
// V_TOTAL  525   lines per frame (vertical_y range 0..V_TOTAL-1)
// TILE_SH  3     log2 of tile size in pixels (TILE = 8)
// COLS     80    tiles per row (H_VIZ>>TILE_SH)
// ROWS     60    tile rows (V_VIZ>>TILE_SH)
// ADDR_W   13    RAM address width (must satisfy 2**ADDR_W >= COLS*ROWS)
// DATA_W   8     tile code width
// CLR_VAL  0     tile code written by the clear sequencer
// PORTS
// clk_fba           in   1       pixel clock, same clock as vga
// rst_fba           in   1       asynchronous, active-low reset
// horizontal_x_fba  in   10      current pixel x from vga
// vertical_y_fba    in   10      current line y from vga
// wr_req_fba        in   1       writer request; held high until ack
// wr_addr_fba       in   ADDR_W  writer tile address
// wr_data_fba       in   DATA_W  writer tile code
// wr_ack_fba        out  1       1-cycle pulse: write performed this cycle
// clr_req_fba       in   1       start full-RAM clear (pulse)
// clr_busy_fba      out  1       clear in progress
// clr_done_fba      out  1       1-cycle pulse after last clear write
// ram_addr_fba      out  ADDR_W  RAM address
// ram_we_fba        out  1       RAM write enable
// ram_wdata_fba     out  DATA_W  RAM write data
// ram_rdata_fba     in   DATA_W  RAM read data; sync RAM, valid the cycle after address
// tile_data_fba     out  DATA_W  latest fetched tile code
// BEHAVIOUR
// Reset (rst_fba low, async):
// - State goes to IDLE; clr_addr=0.
// - tile_data_fba=0, clr_busy_fba=0, clr_done_fba=0, rd_pend=0.
// - The combinational outputs then evaluate to ram_we_fba=0, wr_ack_fba=0, ram_addr_fba=0, ram_wdata_fba=0 whenever no read slot is active.
// Read slot (combinational from x, y); two kinds:
// - In-line: y<V_VIZ && x<H_VIZ-TILE && x[TILE_SH-1:0]==TILE-4.
//   addr = (y>>TILE_SH)*COLS + (x>>TILE_SH) + 1.
// - Line prefetch: x==H_TOTAL-4. Let yn = (y==V_TOTAL-1)?0:y+1. The slot exists only if yn<V_VIZ.
//   addr = (yn>>TILE_SH)*COLS.
// - All address arithmetic is done in ADDR_W bits.
// Read slot cycle timing:
// - ram_addr_fba = slot address, ram_we_fba=0.
// - rd_pend is set at the end of the slot cycle.
// - When rd_pend=1, tile_data_fba <= ram_rdata_fba at that edge and rd_pend clears.
// - So tile_data_fba updates 2 edges after the slot and holds until the next fetch.
// Non-slot cycle, ram_* multiplexer; priority is CLEAR > writer:
// - State CLEAR: ram_we_fba=1, ram_addr_fba=clr_addr, ram_wdata_fba=CLR_VAL; clr_addr increments.
// - State IDLE with wr_req_fba=1: ram_we_fba=1, ram_addr/wdata from wr_*; wr_ack_fba=1 in the same cycle.
// - Otherwise: ram_we_fba=0, ram_addr_fba=0.
// Writer handshake:
// - A request that collides with a read slot is not acked; it waits one or more cycles.
// - No write is acked while clr_busy_fba=1.
// - After ack, the writer changes wr_* or drops req on the next cycle. Req held high = another write.
// FSM IDLE/CLEAR:
// - IDLE -> CLEAR on clr_req_fba=1. clr_addr=0 and clr_busy_fba=1 from the next cycle.
// - A writer ack in that same cycle is still honoured.
// - clr_req_fba in CLEAR is ignored.
// - CLEAR -> IDLE after the write at clr_addr==COLS*ROWS-1. clr_done_fba pulses on the cycle after that write; clr_busy_fba goes low on the same cycle.
// - Clear length = COLS*ROWS writes plus any interleaved read slots.
// Reset mid-clear: returns to IDLE with clr_addr=0. No clr_done_fba pulse.
// Read slots are never skipped or delayed, in any state.
// TESTING
// - Reset: hold rst_fba=0 with random inputs -> tile_data=0, clr_busy=0, clr_done=0. wr_ack and ram_we are 0 whenever no slot is active.
// - Fetch: y=16, x=12 -> ram_addr=2*80+2=162, we=0; tile_data=ram contents(162) 2 edges later. x=636 -> no slot.
// - Wrap: y=524, x=796 -> addr 0. y=479, x=796 -> no slot. y=7, x=796 -> addr 80.
// - Contention: wr_req with addr 5 asserted on a slot cycle (x=4, y=0) -> no ack; ack on x=5 with ram_addr=5, we=1.
// - Clear: clr_req pulse with x held in blanking -> exactly 4800 writes of CLR_VAL, addrs 0..4799, then a clr_done pulse. Concurrent wr_req is never acked until clr_busy=0.
// - Reset mid-clear: assert rst_fba at clr_addr=1000 -> IDLE and no clr_done. A new clr_req restarts at addr 0.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter for the scoreboard tile display.
// Shares one single-port synchronous RAM between three users, highest priority first:
//   - VGA tile fetch slots, derived combinationally from the pixel counters
//   - the built-in clear sequencer, which fills every tile with CLR_VAL
//   - the scoreboard writer, via a req/ack handshake
// Ports:
//   clk_fba, rst_fba            pixel clock, asynchronous active-low reset
//   horizontal_x_fba,
//   vertical_y_fba              current pixel position from the VGA timing counters
//   wr_req/addr/data/ack_fba    writer handshake; ack is a 1-cycle pulse on the write cycle
//   clr_req/busy/done_fba       clear start pulse, busy level, 1-cycle done pulse
//   ram_addr/we/wdata_fba       RAM command; ram_rdata_fba is valid the cycle after address
//   tile_data_fba               latest fetched tile code for the glyph renderer
module vga_fb_arbiter #(
    parameter int unsigned H_VIZ   = 640,
    parameter int unsigned V_VIZ   = 480,
    parameter int unsigned H_TOTAL = 800,
    parameter int unsigned V_TOTAL = 525,
    parameter int unsigned TILE_SH = 3,
    parameter int unsigned COLS    = 80,
    parameter int unsigned ROWS    = 60,
    parameter int unsigned ADDR_W  = 13,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CLR_VAL = 0
) (
    input  logic              clk_fba,
    input  logic              rst_fba,
    input  logic [9:0]        horizontal_x_fba,
    input  logic [9:0]        vertical_y_fba,
    input  logic              wr_req_fba,
    input  logic [ADDR_W-1:0] wr_addr_fba,
    input  logic [DATA_W-1:0] wr_data_fba,
    output logic              wr_ack_fba,
    input  logic              clr_req_fba,
    output logic              clr_busy_fba,
    output logic              clr_done_fba,
    output logic [ADDR_W-1:0] ram_addr_fba,
    output logic              ram_we_fba,
    output logic [DATA_W-1:0] ram_wdata_fba,
    input  logic [DATA_W-1:0] ram_rdata_fba,
    output logic [DATA_W-1:0] tile_data_fba
);

    localparam int unsigned TILE = 1 << TILE_SH;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              clr_done_q, clr_done_d;
    logic              rd_pend_q;
    logic [DATA_W-1:0] tile_data_q;

    logic [9:0]        y_next;
    logic              inline_slot, pre_slot, slot;
    logic [ADDR_W-1:0] inline_addr, pre_addr, slot_addr;

    // Fetch slots: one per tile, four pixels ahead of the tile boundary, plus a
    // prefetch of column 0 of the next line near the end of horizontal blanking.
    always_comb begin
        y_next = (vertical_y_fba == 10'(V_TOTAL - 1)) ? 10'd0 : vertical_y_fba + 10'd1;

        inline_slot = (vertical_y_fba < 10'(V_VIZ))
                   && (horizontal_x_fba < 10'(H_VIZ - TILE))
                   && (horizontal_x_fba[TILE_SH-1:0] == TILE_SH'(TILE - 4));
        pre_slot    = (horizontal_x_fba == 10'(H_TOTAL - 4)) && (y_next < 10'(V_VIZ));

        inline_addr = ADDR_W'(vertical_y_fba >> TILE_SH) * ADDR_W'(COLS)
                    + ADDR_W'(horizontal_x_fba >> TILE_SH) + ADDR_W'(1);
        pre_addr    = ADDR_W'(y_next >> TILE_SH) * ADDR_W'(COLS);

        slot      = inline_slot | pre_slot;
        slot_addr = inline_slot ? inline_addr : pre_addr;
    end

    // RAM port mux and clear FSM next state
    always_comb begin
        state_d       = state_q;
        clr_addr_d    = clr_addr_q;
        clr_done_d    = 1'b0;
        ram_addr_fba  = '0;
        ram_we_fba    = 1'b0;
        ram_wdata_fba = '0;
        wr_ack_fba    = 1'b0;

        if (slot) begin
            // Fetch owns the port; clear pauses and writer waits
            ram_addr_fba = slot_addr;
        end else if (state_q == StClear) begin
            ram_we_fba    = 1'b1;
            ram_addr_fba  = clr_addr_q;
            ram_wdata_fba = DATA_W'(CLR_VAL);
            clr_addr_d    = clr_addr_q + ADDR_W'(1);
            if (clr_addr_q == LAST_ADDR) begin
                state_d    = StIdle;
                clr_addr_d = '0;
                clr_done_d = 1'b1;
            end
        end else if (wr_req_fba && rst_fba) begin
            // No writes are issued while reset is held
            ram_we_fba    = 1'b1;
            ram_addr_fba  = wr_addr_fba;
            ram_wdata_fba = wr_data_fba;
            wr_ack_fba    = 1'b1;
        end

        // A writer ack on the start cycle is still honoured above
        if ((state_q == StIdle) && clr_req_fba) begin
            state_d    = StClear;
            clr_addr_d = '0;
        end
    end

    always_ff @(posedge clk_fba or negedge rst_fba) begin
        if (!rst_fba) begin
            state_q     <= StIdle;
            clr_addr_q  <= '0;
            clr_done_q  <= 1'b0;
            rd_pend_q   <= 1'b0;
            tile_data_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            clr_done_q <= clr_done_d;
            rd_pend_q  <= slot;
            if (rd_pend_q) begin
                tile_data_q <= ram_rdata_fba;
            end
        end
    end

    assign clr_busy_fba  = (state_q == StClear);
    assign clr_done_fba  = clr_done_q;
    assign tile_data_fba = tile_data_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic        wr_req = 1'b0;
    logic [12:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        wr_ack;
    logic        clr_req = 1'b0;
    logic        clr_busy;
    logic        clr_done;
    logic [12:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [7:0]  tile_data;

    int checks = 0;
    int failures = 0;

    bit [7:0] mem [0:8191];

    always #5 clk = ~clk;

    // Synchronous single-port RAM model
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    vga_fb_arbiter dut (
        .clk_fba          (clk),
        .rst_fba          (rst),
        .horizontal_x_fba (x),
        .vertical_y_fba   (y),
        .wr_req_fba       (wr_req),
        .wr_addr_fba      (wr_addr),
        .wr_data_fba      (wr_data),
        .wr_ack_fba       (wr_ack),
        .clr_req_fba      (clr_req),
        .clr_busy_fba     (clr_busy),
        .clr_done_fba     (clr_done),
        .ram_addr_fba     (ram_addr),
        .ram_we_fba       (ram_we),
        .ram_wdata_fba    (ram_wdata),
        .ram_rdata_fba    (ram_rdata),
        .tile_data_fba    (tile_data)
    );

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        req;
        logic [12:0] addr;
        logic [7:0]  data;
        logic [12:0] exp_addr;
        logic        exp_we;
        logic        exp_ack;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, settle before sampling
    task automatic drive(input logic [9:0] dx, input logic [9:0] dy, input logic req,
                         input logic [12:0] addr, input logic [7:0] data, input logic clr);
        @(negedge clk);
        x = dx; y = dy; wr_req = req; wr_addr = addr; wr_data = data; clr_req = clr;
        #1;
    endtask

    initial begin
        int n_writes, bad, acked, done_seen;
        logic [12:0] exp_addr;

        vecs[0] = '{10'd12,  10'd16,  1'b0, 13'd0,  8'h00, 13'd162,  1'b0, 1'b0};
        vecs[1] = '{10'd636, 10'd16,  1'b0, 13'd0,  8'h00, 13'd0,    1'b0, 1'b0};
        vecs[2] = '{10'd796, 10'd524, 1'b1, 13'd77, 8'h11, 13'd0,    1'b0, 1'b0};
        vecs[3] = '{10'd796, 10'd479, 1'b1, 13'd77, 8'h11, 13'd77,   1'b1, 1'b1};
        vecs[4] = '{10'd796, 10'd7,   1'b0, 13'd0,  8'h00, 13'd80,   1'b0, 1'b0};
        vecs[5] = '{10'd4,   10'd0,   1'b1, 13'd5,  8'h22, 13'd1,    1'b0, 1'b0};
        vecs[6] = '{10'd5,   10'd0,   1'b1, 13'd5,  8'h22, 13'd5,    1'b1, 1'b1};
        vecs[7] = '{10'd628, 10'd472, 1'b0, 13'd0,  8'h00, 13'd4799, 1'b0, 1'b0};
        vecs[8] = '{10'd12,  10'd480, 1'b1, 13'd10, 8'h33, 13'd10,   1'b1, 1'b1};
        vecs[9] = '{10'd796, 10'd523, 1'b1, 13'd10, 8'h44, 13'd10,   1'b1, 1'b1};

        // Reset with random inputs; x kept in 640..795 so no slot is active
        #2 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(10'(640 + $urandom_range(0, 155)), 10'($urandom_range(0, 524)),
                  1'($urandom_range(0, 1)), 13'($urandom_range(0, 8191)),
                  8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            check("rst_tile_data", 32'(tile_data), 32'h0);
            check("rst_clr_busy", 32'(clr_busy), 32'h0);
            check("rst_clr_done", 32'(clr_done), 32'h0);
            check("rst_ram_we", 32'(ram_we), 32'h0);
            check("rst_wr_ack", 32'(wr_ack), 32'h0);
        end
        drive(10'd700, 10'd500, 1'b0, 13'd0, 8'h00, 1'b0);
        rst = 1'b1;
        drive(10'd700, 10'd500, 1'b0, 13'd0, 8'h00, 1'b0);
        check("idle_ram_addr", 32'(ram_addr), 32'h0);

        // Slot decoding and writer arbitration vectors
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].x, vecs[i].y, vecs[i].req, vecs[i].addr, vecs[i].data, 1'b0);
            check($sformatf("vec%0d_addr", i), 32'(ram_addr), 32'(vecs[i].exp_addr));
            check($sformatf("vec%0d_we", i), 32'(ram_we), 32'(vecs[i].exp_we));
            check($sformatf("vec%0d_ack", i), 32'(wr_ack), 32'(vecs[i].exp_ack));
            if (vecs[i].exp_we)
                check($sformatf("vec%0d_wdata", i), 32'(ram_wdata), 32'(vecs[i].data));
        end

        // Fetch latency: write A5 to tile 162, fetch it, expect it two edges later
        drive(10'd700, 10'd500, 1'b1, 13'd162, 8'hA5, 1'b0);
        check("pre_wr_ack", 32'(wr_ack), 32'h1);
        drive(10'd12, 10'd16, 1'b0, 13'd0, 8'h00, 1'b0);
        check("fetch_addr", 32'(ram_addr), 32'd162);
        drive(10'd13, 10'd16, 1'b0, 13'd0, 8'h00, 1'b0);
        check("fetch_early", 32'(tile_data), 32'h0);
        drive(10'd14, 10'd16, 1'b0, 13'd0, 8'h00, 1'b0);
        check("fetch_data", 32'(tile_data), 32'hA5);

        // Full clear with the writer requesting throughout and one fetch slot inside
        drive(10'd700, 10'd500, 1'b0, 13'd0, 8'h00, 1'b1);
        check("clr_start_busy", 32'(clr_busy), 32'h0);
        n_writes = 0; bad = 0; acked = 0; done_seen = 0; exp_addr = '0;
        for (int c = 0; c < 6000 && done_seen == 0; c++) begin
            if (c == 100) drive(10'd796, 10'd7, 1'b1, 13'd9, 8'h33, 1'b0);
            else drive(10'd700, 10'd500, 1'b1, 13'd9, 8'h33, 1'b0);
            if (clr_done) begin
                done_seen = 1;
                check("done_busy", 32'(clr_busy), 32'h0);
                check("done_wr_ack", 32'(wr_ack), 32'h1);
                check("done_wr_addr", 32'(ram_addr), 32'd9);
            end else begin
                if (!clr_busy) bad++;
                if (wr_ack) acked++;
                if (c == 100 && (ram_we || ram_addr != 13'd80)) bad++;
                if (ram_we) begin
                    if (ram_addr != exp_addr || ram_wdata != 8'h00) bad++;
                    exp_addr++;
                    n_writes++;
                end
            end
        end
        check("clr_done_seen", 32'(done_seen), 32'h1);
        check("clr_writes", 32'(n_writes), 32'd4800);
        check("clr_bad_cycles", 32'(bad), 32'h0);
        check("clr_acks_while_busy", 32'(acked), 32'h0);
        drive(10'd700, 10'd500, 1'b0, 13'd0, 8'h00, 1'b0);
        check("done_pulse_len", 32'(clr_done), 32'h0);

        // Tile 162 now holds CLR_VAL
        drive(10'd12, 10'd16, 1'b0, 13'd0, 8'h00, 1'b0);
        drive(10'd13, 10'd16, 1'b0, 13'd0, 8'h00, 1'b0);
        drive(10'd14, 10'd16, 1'b0, 13'd0, 8'h00, 1'b0);
        check("fetch_cleared", 32'(tile_data), 32'h0);

        // Reset mid-clear at clr_addr = 1000
        drive(10'd700, 10'd500, 1'b0, 13'd0, 8'h00, 1'b1);
        n_writes = 0;
        for (int c = 0; c < 2000 && n_writes < 1000; c++) begin
            drive(10'd700, 10'd500, 1'b0, 13'd0, 8'h00, 1'b0);
            if (ram_we) n_writes++;
        end
        check("mid_writes", 32'(n_writes), 32'd1000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_busy", 32'(clr_busy), 32'h0);
        check("mid_rst_done", 32'(clr_done), 32'h0);
        drive(10'd700, 10'd500, 1'b0, 13'd0, 8'h00, 1'b0);
        rst = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 3; c++) begin
            drive(10'd700, 10'd500, 1'b0, 13'd0, 8'h00, 1'b0);
            if (clr_done || ram_we || clr_busy) done_seen++;
        end
        check("mid_rst_quiet", 32'(done_seen), 32'h0);
        drive(10'd700, 10'd500, 1'b0, 13'd0, 8'h00, 1'b1);
        drive(10'd700, 10'd500, 1'b0, 13'd0, 8'h00, 1'b0);
        check("restart_we", 32'(ram_we), 32'h1);
        check("restart_addr", 32'(ram_addr), 32'h0);
        check("restart_busy", 32'(clr_busy), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
